// File: rtl/muldiv_sequencer_pkg.sv
// Shared RV32M types for the EX-stage multiply/divide sequencer.
package rv32i_types;

    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011,
        div    = 3'b100,
        divu   = 3'b101,
        rem    = 3'b110,
        remu   = 3'b111
    } muldiv_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } muldiv_state_t;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand conditioning for the muldiv sequencer: signedness decode, magnitudes,
// result negation flag and the no-iteration special cases (MULDIV_EARLY_OUT_EN adds zero shortcuts).
module muldiv_operand_prep
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  muldiv_funct3_t   op,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    output logic             neg_res,
    output logic             special,
    output logic [WIDTH-1:0] special_res
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed_a, signed_b, s_a, s_b, is_div, is_rem;

    always_comb begin
        signed_a    = op inside {mulh, mulhsu, div, rem};
        signed_b    = op inside {mulh, div, rem};
        s_a         = signed_a & rs1_val[WIDTH-1];
        s_b         = signed_b & rs2_val[WIDTH-1];
        mag_a       = s_a ? -rs1_val : rs1_val;
        mag_b       = s_b ? -rs2_val : rs2_val;
        is_div      = op[2];
        is_rem      = op[2] & op[1];
        // Remainder takes the dividend's sign; product and quotient take sA^sB.
        neg_res     = is_rem ? s_a : (s_a ^ s_b);
        special     = 1'b0;
        special_res = '0;
        if (is_div && rs2_val == '0) begin
            special     = 1'b1;
            special_res = is_rem ? rs1_val : '1;
        end else if (is_div && signed_b && rs1_val == MIN_VAL && rs2_val == '1) begin
            special     = 1'b1;
            special_res = is_rem ? '0 : MIN_VAL;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (is_div && mag_a == '0) begin
            special     = 1'b1;
            special_res = '0;
        end else if (!is_div && mag_b == '0) begin
            special     = 1'b1;
            special_res = '0;
        end
`endif
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide engine with its control FSM (one bit per cycle).
// Optional MULDIV_EARLY_OUT_EN: MUL stops once the remaining multiplier bits are zero.
module muldiv_sequencer
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    muldiv_state_t    state_q, state_d;
    muldiv_funct3_t   f3_q, f3_d, op_in;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   mag_a, mag_b, special_res, div_pick;
    logic               neg_res, special, last_mul;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;

    assign op_in = muldiv_funct3_t'(funct3);

    muldiv_operand_prep #(.WIDTH(WIDTH)) u_prep (
        .op          (op_in),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .mag_a       (mag_a),
        .mag_b       (mag_b),
        .neg_res     (neg_res),
        .special     (special),
        .special_res (special_res)
    );

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        result_d  = result_q;
        busy      = 1'b0;
        div_trial = '0;
        prod_fix  = '0;
        div_pick  = '0;
        last_mul  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = start & ~flush;
                if (start && !flush) begin
                    f3_d  = op_in;
                    neg_d = neg_res;
                    cnt_d = '0;
                    if (special) begin
                        result_d = special_res;
                        state_d  = DONE;
                    end else if (!funct3[2]) begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, mag_a};
                        mplier_d = mag_b;
                        state_d  = MUL;
                    end else begin
                        // acc holds {remainder, dividend/quotient}; divisor sits in mcand low half.
                        acc_d    = {{WIDTH{1'b0}}, mag_a};
                        mcand_d  = {{WIDTH{1'b0}}, mag_b};
                        state_d  = DIV;
                    end
                end
            end
            MUL: begin
                busy     = 1'b1;
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                last_mul = (cnt_q == LAST) || (mplier_d == '0);
`else
                last_mul = (cnt_q == LAST);
`endif
                if (last_mul) begin
                    prod_fix = neg_q ? -acc_d : acc_d;
                    result_d = (f3_q == mul) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
                    state_d  = DONE;
                end
            end
            DIV: begin
                busy      = 1'b1;
                div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q[WIDTH-1:0]};
                if (!div_trial[WIDTH])
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    div_pick = f3_q[1] ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
                    result_d = neg_q ? -div_pick : div_pick;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A flushed op must leave no trace on the visible result.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            f3_q     <= mul;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            f3_q     <= f3_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
        end
    end

    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed literal cases plus randomized ops
// checked every cycle against an arithmetic/event-level reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic        busy, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit          m_inflight = 1'b0;
    int          m_done_cyc = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_res = '0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        bit ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        ovf = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    // Reference model: when done is due, which result is visible, what busy must be.
    always @(posedge clk) begin
        if (rst) begin
            m_inflight = 1'b0;
            m_res      = '0;
        end else if (flush) begin
            m_inflight = 1'b0;
        end else if (m_inflight && cyc == m_done_cyc) begin
            m_inflight = 1'b0;
        end else if (!m_inflight && start) begin
            m_inflight = 1'b1;
            m_done_cyc = cyc + (is_special(funct3, rs1_val, rs2_val) ? 1 : 33);
            m_pend     = ref_res(funct3, rs1_val, rs2_val);
        end
        if (m_inflight && cyc + 1 == m_done_cyc) m_res = m_pend;
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst && cyc > 0) begin
            chk("busy", busy, m_inflight ? (cyc < m_done_cyc) : (start && !flush));
            chk("done", done, m_inflight && cyc == m_done_cyc);
            chk("result", result, m_res);
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm);
        int t0, seen;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        seen = -1;
        for (int i = 0; i < 40 && seen < 0; i++) begin
            @(negedge clk);
            if (done) seen = cyc;
        end
        chk({nm, " latency"}, 32'(seen - t0), 32'(lat));
        chk({nm, " value"}, result, exp);
    endtask

    task automatic count_done(input int n, output int nd);
        nd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t0, nd, seen, d;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul 7*-3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div -7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem -7/2");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu 100/7");
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu by 0");
        run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem by 0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div ovf");

        // Flush mid-multiply
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; rs1_val = 32'd123; rs2_val = 32'd456; t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush busy drop", busy, 0);
        count_done(40, nd);
        chk("flush no done", nd, 0);
        run_op(3'd4, 32'd9, 32'd3, 32'd3, 33, "div 9/3");

        // start held through DONE launches once
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd5;
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("held start done", seen, 1);
        chk("held start value", result, 32'd15);
        @(posedge clk); #1 start = 1'b0;
        count_done(40, nd);
        chk("held start no extra done", nd, 0);

        // start and flush together: no launch
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; rs1_val = 32'd50; rs2_val = 32'd0;
        @(negedge clk);
        chk("start+flush busy", busy, 0);
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        count_done(40, nd);
        chk("start+flush no done", nd, 0);

        // rst mid-op
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd7;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        count_done(40, nd);
        chk("rst no done", nd, 0);

        // Randomized ops with occasional flush
        for (int n = 0; n < 150; n++) begin
            @(posedge clk); #1;
            start = 1'b1; funct3 = 3'($urandom_range(0, 7)); rs1_val = pick(); rs2_val = pick();
            @(posedge clk); #1 start = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                d = $urandom_range(1, 30);
                repeat (d - 1) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk); #1 flush = 1'b0;
            end
            for (int i = 0; i < 40 && m_inflight; i++) @(negedge clk);
            if (m_inflight) chk("random op timeout", 1, 0);
            @(negedge clk);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
